wb_rf_write_arbiter: RTL and testbench

//  Shares the single register-file write port between the in-order WB stage and one

---
 rtl/wb_rf_write_arbiter.sv | 165 ++++++++++++++++
 tb/tb_wb_rf_write_arbiter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_rf_write_arbiter.sv
// Register-file write-port arbiter: in-order WB writes win, a one-entry holding register
// parks secondary-unit results. Define WB_ARB_PERF_EN to build the force/drop counters.
module wb_rf_write_arbiter #(
  parameter int ADDR_W       = 7,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              wb_regwrite,
  input  logic              wb_cancel,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              sec_valid,
  output logic              sec_ready,
  input  logic [ADDR_W-1:0] sec_addr,
  input  logic [DATA_W-1:0] sec_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              stall_req,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [31:0]       perf_force,
  output logic [31:0]       perf_drop
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, PEND, FORCE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] pend_addr_q;
  logic [DATA_W-1:0] pend_data_q;
  logic [CNT_W-1:0]  wait_cnt;

  logic pipe_w;
  logic pend_hit;
  logic sec_accept;
  logic idle_drop;
  logic starve;

  assign pipe_w     = wb_regwrite & ~wb_cancel & (wb_addr != '0);
  assign pend_hit   = pipe_w & (wb_addr == pend_addr_q);
  assign sec_accept = sec_valid & sec_ready & (state == IDLE);
  // A same-cycle pipe write to the same register is younger, so the secondary result is stale.
  assign idle_drop  = (sec_addr == '0) | (pipe_w & (wb_addr == sec_addr));
  assign starve     = (int'(wait_cnt) + 1 >= STARVE_LIMIT - 1);

  assign pend_addr  = pend_addr_q;

  // Port mux is combinational so pipeline writes land with zero latency.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    rf_we    = 1'b0;
    rf_waddr = wb_addr;
    rf_wdata = wb_data;
    unique case (state)
      IDLE: rf_we = pipe_w;
      PEND: begin
        if (pipe_w) begin
          rf_we = 1'b1;
        end else begin
          rf_we    = 1'b1;
          rf_waddr = pend_addr_q;
          rf_wdata = pend_data_q;
        end
      end
      FORCE: begin
        rf_we    = ~pend_hit;
        rf_waddr = pend_addr_q;
        rf_wdata = pend_data_q;
      end
      default: rf_we = 1'b0;
    endcase
  end

  // NOTE: non-blocking assignments for all sequential state so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state       <= IDLE;
      pend_valid  <= 1'b0;
      pend_addr_q <= '0;
      wait_cnt    <= '0;
      stall_req   <= 1'b0;
      sec_ready   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (sec_accept && !idle_drop) begin
            state       <= PEND;
            pend_valid  <= 1'b1;
            pend_addr_q <= sec_addr;
            wait_cnt    <= '0;
            sec_ready   <= 1'b0;
          end else begin
            sec_ready   <= 1'b1;
          end
        end
        PEND: begin
          if (pend_hit) begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            sec_ready  <= 1'b1;
          end else if (pipe_w) begin
            wait_cnt <= wait_cnt + 1'b1;
            if (starve) begin
              state     <= FORCE;
              stall_req <= 1'b1;
            end
          end else begin
            state      <= IDLE;
            pend_valid <= 1'b0;
            sec_ready  <= 1'b1;
          end
        end
        FORCE: begin
          state      <= IDLE;
          stall_req  <= 1'b0;
          pend_valid <= 1'b0;
          sec_ready  <= 1'b1;
        end
        default: begin
          state      <= IDLE;
          stall_req  <= 1'b0;
          pend_valid <= 1'b0;
          sec_ready  <= 1'b0;
        end
      endcase
    end
  end

  // NOTE: the held data is pure payload qualified by pend_valid, so it carries no reset.
  always_ff @(posedge aclk) begin
    if (sec_accept && !idle_drop) pend_data_q <= sec_data;
  end

`ifdef WB_ARB_PERF_EN
  logic        force_evt;
  logic        drop_evt;
  logic [31:0] force_cnt;
  logic [31:0] drop_cnt;

  assign force_evt = (state == PEND) & pipe_w & ~pend_hit & starve;
  assign drop_evt  = (sec_accept & idle_drop) | ((state != IDLE) & pend_hit);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      force_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      if (force_evt) force_cnt <= force_cnt + 32'd1;
      if (drop_evt)  drop_cnt  <= drop_cnt + 32'd1;
    end
  end

  assign perf_force = force_cnt;
  assign perf_drop  = drop_cnt;
`else
  assign perf_force = '0;
  assign perf_drop  = '0;
`endif

endmodule

// File: tb/tb_wb_rf_write_arbiter.sv
// Self-checking bench for wb_rf_write_arbiter: cycle vector table with an RF-write
// scoreboard, plus a hand-written reset-during-PEND sequence.
module tb_wb_rf_write_arbiter;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        wb_regwrite, wb_cancel;
  logic [6:0]  wb_addr;
  logic [31:0] wb_data;
  logic        sec_valid, sec_ready;
  logic [6:0]  sec_addr;
  logic [31:0] sec_data;
  logic        rf_we;
  logic [6:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        stall_req, pend_valid;
  logic [6:0]  pend_addr;
  logic [31:0] perf_force, perf_drop;

  always #5 aclk = ~aclk;

  wb_rf_write_arbiter dut (
    .aclk(aclk), .aresetn(aresetn),
    .wb_regwrite(wb_regwrite), .wb_cancel(wb_cancel), .wb_addr(wb_addr), .wb_data(wb_data),
    .sec_valid(sec_valid), .sec_ready(sec_ready), .sec_addr(sec_addr), .sec_data(sec_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .stall_req(stall_req), .pend_valid(pend_valid), .pend_addr(pend_addr),
    .perf_force(perf_force), .perf_drop(perf_drop)
  );

  typedef struct {
    logic        wr, cancel;
    logic [6:0]  wa;
    logic [31:0] wd;
    logic        sv;
    logic [6:0]  sa;
    logic [31:0] sd;
    logic        exp_we;
    logic [6:0]  exp_wa;
    logic [31:0] exp_wd;
    logic        exp_stall, exp_pend, exp_ready;
  } vec_t;

  typedef struct {
    logic [6:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t vecs[$];
  wr_t  sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic wr, cancel, input logic [6:0] wa, input logic [31:0] wd,
                     input logic sv, input logic [6:0] sa, input logic [31:0] sd,
                     input logic ewe, input logic [6:0] ewa, input logic [31:0] ewd,
                     input logic est, epd, erd);
    vec_t v;
    v.wr = wr; v.cancel = cancel; v.wa = wa; v.wd = wd;
    v.sv = sv; v.sa = sa; v.sd = sd;
    v.exp_we = ewe; v.exp_wa = ewa; v.exp_wd = ewd;
    v.exp_stall = est; v.exp_pend = epd; v.exp_ready = erd;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    wb_regwrite = 0; wb_cancel = 0; wb_addr = '0; wb_data = '0;
    sec_valid = 0; sec_addr = '0; sec_data = '0;
  endtask

  // Compares the RF write port against the scoreboard head for this cycle.
  task automatic sample_writes();
    logic exp_we;
    wr_t  e;
    exp_we = (sb.size() != 0);
    check("rf_we", {31'b0, rf_we}, {31'b0, exp_we});
    if (exp_we) begin
      e = sb.pop_front();
      if (rf_we === 1'b1) begin
        check("rf_waddr", {25'b0, rf_waddr}, {25'b0, e.addr});
        check("rf_wdata", rf_wdata, e.data);
      end
    end
  endtask

  initial begin
    aresetn = 1'b0;
    idle_inputs();

    //   wr cn wa     wd            sv sa     sd            we wa     wd            st pd rd
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);
    // Idle-port secondary write lands the cycle after acceptance
    add(0, 0, 7'd0,  32'h0,        1, 7'd5,  32'hDEADBEEF, 0, 7'd0,  32'h0,        0, 0, 1);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        1, 7'd5,  32'hDEADBEEF, 0, 1, 0);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);
    // Starvation: three lost cycles, forced stall, then the held WB write
    add(1, 0, 7'd3,  32'h30,       1, 7'd8,  32'h80,       1, 7'd3,  32'h30,       0, 0, 1);
    add(1, 0, 7'd3,  32'h31,       0, 7'd0,  32'h0,        1, 7'd3,  32'h31,       0, 1, 0);
    add(1, 0, 7'd3,  32'h32,       0, 7'd0,  32'h0,        1, 7'd3,  32'h32,       0, 1, 0);
    add(1, 0, 7'd3,  32'h33,       0, 7'd0,  32'h0,        1, 7'd3,  32'h33,       0, 1, 0);
    add(1, 0, 7'd3,  32'h34,       0, 7'd0,  32'h0,        1, 7'd8,  32'h80,       1, 1, 0);
    add(1, 0, 7'd3,  32'h34,       0, 7'd0,  32'h0,        1, 7'd3,  32'h34,       0, 0, 1);
    // Younger pipe write supersedes the pending entry
    add(0, 0, 7'd0,  32'h0,        1, 7'd9,  32'h99,       0, 7'd0,  32'h0,        0, 0, 1);
    add(1, 0, 7'd9,  32'h1,        0, 7'd0,  32'h0,        1, 7'd9,  32'h1,        0, 1, 0);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);
    // Cancelled WB write leaves the port to the entry
    add(0, 0, 7'd0,  32'h0,        1, 7'd10, 32'hA5A5A5A5, 0, 7'd0,  32'h0,        0, 0, 1);
    add(1, 1, 7'd12, 32'hBAD,      0, 7'd0,  32'h0,        1, 7'd10, 32'hA5A5A5A5, 0, 1, 0);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);
    // Address 0 on both sides: nothing written, nothing held
    add(1, 0, 7'd0,  32'h77,       1, 7'd0,  32'h55,       0, 7'd0,  32'h0,        0, 0, 1);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);
    // Same-cycle collision in IDLE drops the secondary result
    add(1, 0, 7'd17, 32'h111,      1, 7'd17, 32'h222,      1, 7'd17, 32'h111,      0, 0, 1);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);
    // Forced cycle where the held WB write targets the entry: nothing written
    add(1, 0, 7'd4,  32'h40,       1, 7'd6,  32'h60,       1, 7'd4,  32'h40,       0, 0, 1);
    add(1, 0, 7'd4,  32'h41,       0, 7'd0,  32'h0,        1, 7'd4,  32'h41,       0, 1, 0);
    add(1, 0, 7'd4,  32'h42,       0, 7'd0,  32'h0,        1, 7'd4,  32'h42,       0, 1, 0);
    add(1, 0, 7'd4,  32'h43,       0, 7'd0,  32'h0,        1, 7'd4,  32'h43,       0, 1, 0);
    add(1, 0, 7'd6,  32'h66,       0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        1, 1, 0);
    add(1, 0, 7'd6,  32'h66,       0, 7'd0,  32'h0,        1, 7'd6,  32'h66,       0, 0, 1);
    // Offer while holding register is busy is not accepted
    add(0, 0, 7'd0,  32'h0,        1, 7'd32, 32'h2020,     0, 7'd0,  32'h0,        0, 0, 1);
    add(0, 0, 7'd0,  32'h0,        1, 7'd33, 32'h2121,     1, 7'd32, 32'h2020,     0, 1, 0);
    add(0, 0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 7'd0,  32'h0,        0, 0, 1);

    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("reset rf_we", {31'b0, rf_we}, 32'd0);
    check("reset stall_req", {31'b0, stall_req}, 32'd0);
    check("reset pend_valid", {31'b0, pend_valid}, 32'd0);
    check("reset sec_ready", {31'b0, sec_ready}, 32'd0);
    check("reset perf_force", perf_force, 32'd0);
    check("reset perf_drop", perf_drop, 32'd0);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      wb_regwrite = vecs[i].wr; wb_cancel = vecs[i].cancel;
      wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
      sec_valid = vecs[i].sv; sec_addr = vecs[i].sa; sec_data = vecs[i].sd;
      if (vecs[i].exp_we) begin
        wr_t w;
        w.addr = vecs[i].exp_wa;
        w.data = vecs[i].exp_wd;
        sb.push_back(w);
      end
      @(negedge aclk);
      sample_writes();
      check($sformatf("v%0d stall_req", i), {31'b0, stall_req}, {31'b0, vecs[i].exp_stall});
      check($sformatf("v%0d pend_valid", i), {31'b0, pend_valid}, {31'b0, vecs[i].exp_pend});
      check($sformatf("v%0d sec_ready", i), {31'b0, sec_ready}, {31'b0, vecs[i].exp_ready});
      @(posedge aclk);
      #1;
    end
    idle_inputs();

`ifdef WB_ARB_PERF_EN
    check("perf_force", perf_force, 32'd2);
    check("perf_drop", perf_drop, 32'd4);
`else
    check("perf_force tied", perf_force, 32'd0);
    check("perf_drop tied", perf_drop, 32'd0);
`endif

    // Reset while an entry is pending discards it without a write
    sec_valid = 1; sec_addr = 7'd15; sec_data = 32'hF0F0;
    @(posedge aclk);
    #1;
    sec_valid = 0; sec_addr = '0; sec_data = '0;
    check("pend_valid before reset", {31'b0, pend_valid}, 32'd1);
    check("pend_addr before reset", {25'b0, pend_addr}, 32'd15);
    aresetn = 1'b0;
    #1;
    check("mid reset pend_valid", {31'b0, pend_valid}, 32'd0);
    check("mid reset stall_req", {31'b0, stall_req}, 32'd0);
    check("mid reset rf_we", {31'b0, rf_we}, 32'd0);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge aclk);
      #1;
      @(negedge aclk);
      sample_writes();
      check($sformatf("post reset pend_valid %0d", c), {31'b0, pend_valid}, 32'd0);
    end
    check("post reset perf_drop", perf_drop, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
